// File: rtl/matrix_key_pkg.sv
// Shared types and width helpers for the matrix keypad scanner.
package matrix_key_pkg;

    // Scanner phases; exported unchanged on the debug port.
    typedef enum logic [1:0] {
        ST_SCAN      = 2'd0,
        ST_PRESS_DEB = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_DEB   = 2'd3
    } scan_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int code_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shared counter width: wide enough for the largest terminal count.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return code_width(m);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
// Resets to all ones so an idle (pulled-up) keypad is seen after reset.
module key_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages; the first may go metastable, the second is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/matrix_key_scan.sv
// ROWS x COLS keypad scanner: one-cold row strobes, press/release debounce,
// multi-key rejection, release events and optional auto-repeat.
//
// Handshake: there is no back-pressure. key_vld, key_rel and key_multi are
// single-cycle pulses the consumer must take in the cycle they appear;
// key_rpt qualifies key_vld and key_code stays valid until the next
// accepted single-key press.
module matrix_key_scan
    import matrix_key_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_CYC   = 50_000,
    parameter int DEB_CYC    = 1_000_000,
    parameter int REPEAT_EN  = 0,
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000,
    parameter int CW         = code_width(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] key_col,
    output logic [ROWS-1:0] key_row,
    output logic [CW-1:0]   key_code,
    output logic            key_vld,
    output logic            key_rpt,
    output logic            key_rel,
    output logic            key_multi,
    output logic [1:0]      dbg_state
);

    localparam int RW    = code_width(ROWS);
    localparam int CLW   = code_width(COLS);
    localparam int CNT_W = cnt_width(SCAN_CYC, DEB_CYC, REPEAT_DLY, REPEAT_PER);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(REPEAT_PER - 1);

    logic [COLS-1:0]  col_s;
    scan_state_t      state, state_nxt;
    logic [RW-1:0]    row_idx, row_nxt, row_adv;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt, rpt_last;
    logic             rpt_per_q, rpt_per_nxt;
    logic [COLS-1:0]  pat, pat_nxt;
    logic             single_q, single_nxt;
    logic [CW-1:0]    code_nxt;
    logic             vld_nxt, rpt_nxt, rel_nxt, multi_nxt;
    logic             col_idle;
    logic             pat_single;
    logic [CLW-1:0]   low_col;
    logic [CW-1:0]    pat_code;

    key_sync #(.W(COLS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_col),
        .q   (col_s)
    );

    assign dbg_state = state;
    assign col_idle  = &col_s;
    assign row_adv   = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
    assign rpt_last  = rpt_per_q ? PER_LAST : DLY_LAST;

    // Decode the latched column pattern: how many keys and which column.
    always_comb begin
        low_col = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!pat[c]) low_col = CLW'(c);
        end
        pat_single = ($countones(~pat) == 1);
        pat_code   = CW'(int'(row_idx) * COLS + int'(low_col));
    end

    // Next-state, counter and event logic; everything holds unless a branch moves it.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row_idx;
        cnt_nxt     = cnt;
        rpt_cnt_nxt = rpt_cnt;
        rpt_per_nxt = rpt_per_q;
        pat_nxt     = pat;
        single_nxt  = single_q;
        code_nxt    = key_code;
        vld_nxt     = 1'b0;
        rpt_nxt     = 1'b0;
        rel_nxt     = 1'b0;
        multi_nxt   = 1'b0;
        case (state)
            ST_SCAN: begin
                if (cnt == SCAN_LAST) begin
                    cnt_nxt = '0;
                    if (col_idle) begin
                        row_nxt = row_adv;
                    end else begin
                        pat_nxt   = col_s;
                        state_nxt = ST_PRESS_DEB;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_PRESS_DEB: begin
                if (col_idle) begin
                    state_nxt = ST_SCAN;
                    row_nxt   = row_adv;
                    cnt_nxt   = '0;
                end else if (col_s != pat) begin
                    // Contacts still settling: restart on the new pattern.
                    pat_nxt = col_s;
                    cnt_nxt = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_nxt     = '0;
                    rpt_cnt_nxt = '0;
                    rpt_per_nxt = 1'b0;
                    single_nxt  = pat_single;
                    state_nxt   = ST_HELD;
                    if (pat_single) begin
                        vld_nxt  = 1'b1;
                        code_nxt = pat_code;
                    end else begin
                        multi_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (col_idle) begin
                    state_nxt = ST_REL_DEB;
                    cnt_nxt   = '0;
                end else if (REPEAT_EN != 0 && single_q) begin
                    if (rpt_cnt == rpt_last) begin
                        rpt_cnt_nxt = '0;
                        rpt_per_nxt = 1'b1;
                        vld_nxt     = 1'b1;
                        rpt_nxt     = 1'b1;
                    end else begin
                        rpt_cnt_nxt = rpt_cnt + CNT_W'(1);
                    end
                end
            end
            ST_REL_DEB: begin
                if (!col_idle) begin
                    // Release bounce: key still down, repeat delay starts over.
                    state_nxt   = ST_HELD;
                    cnt_nxt     = '0;
                    rpt_cnt_nxt = '0;
                    rpt_per_nxt = 1'b0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = ST_SCAN;
                    cnt_nxt   = '0;
                    row_nxt   = row_adv;
                    rel_nxt   = single_q;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_SCAN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            row_idx   <= '0;
            key_row   <= ~ROWS'(1);
            cnt       <= '0;
            rpt_cnt   <= '0;
            rpt_per_q <= 1'b0;
            pat       <= '1;
            single_q  <= 1'b0;
            key_code  <= '0;
            key_vld   <= 1'b0;
            key_rpt   <= 1'b0;
            key_rel   <= 1'b0;
            key_multi <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_nxt;
            key_row   <= ~(ROWS'(1) << row_nxt);
            cnt       <= cnt_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            rpt_per_q <= rpt_per_nxt;
            pat       <= pat_nxt;
            single_q  <= single_nxt;
            key_code  <= code_nxt;
            key_vld   <= vld_nxt;
            key_rpt   <= rpt_nxt;
            key_rel   <= rel_nxt;
            key_multi <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: a keypad model drives the columns from the row
// strobes, a procedural timed reference predicts every output each cycle,
// and directed scenarios pin event counts with literal values.
module tb_matrix_key_scan;
  import matrix_key_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN_CYC = 8;
  localparam int DEB_CYC = 16;
  localparam int REPEAT_EN = 1;
  localparam int REPEAT_DLY = 40;
  localparam int REPEAT_PER = 10;
  localparam int CW = 4;
  localparam logic [COLS-1:0] ALL_HIGH = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [COLS-1:0] key_col = '1;
  logic [ROWS-1:0] key_row;
  logic [CW-1:0]   key_code;
  logic            key_vld, key_rpt, key_rel, key_multi;
  logic [1:0]      dbg_state;

  matrix_key_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_CYC(SCAN_CYC), .DEB_CYC(DEB_CYC),
    .REPEAT_EN(REPEAT_EN), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
  ) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .key_code(key_code), .key_vld(key_vld), .key_rpt(key_rpt),
    .key_rel(key_rel), .key_multi(key_multi), .dbg_state(dbg_state)
  );

  // ---------------- keypad ----------------
  bit pressed [ROWS][COLS];

  function automatic logic [COLS-1:0] keypad(input int row);
    logic [COLS-1:0] v;
    v = '1;
    for (int c = 0; c < COLS; c++) if (pressed[row][c]) v[c] = 1'b0;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [COLS-1:0] s1, s2;
  int          m_row, m_code;
  bit          m_vld, m_rpt, m_rel, m_multi;
  scan_state_t m_phase;
  bit          abort, live;
  logic [CW:0] exp_q[$];

  function automatic int low_index(input logic [COLS-1:0] p);
    for (int c = 0; c < COLS; c++) if (!p[c]) return c;
    return 0;
  endfunction

  task automatic tick(output logic [COLS-1:0] cs);
    logic [COLS-1:0] raw;
    @(posedge clk);
    raw = keypad(m_row);
    m_vld = 0; m_rpt = 0; m_rel = 0; m_multi = 0;
    if (rst) begin
      live = 1; abort = 1; s1 = '1; s2 = '1;
      m_row = 0; m_code = 0; m_phase = ST_SCAN; cs = '1;
    end else begin
      cs = s2; s2 = s1; s1 = raw;
    end
  endtask

  task automatic emit_vld(input bit rpt);
    m_vld = 1; m_rpt = rpt;
    exp_q.push_back({rpt, CW'(m_code)});
  endtask

  task automatic model_run();
    logic [COLS-1:0] cs, pat;
    int n, wait_rpt;
    bit single, to_scan, released;
    forever begin
      m_phase = ST_SCAN;
      for (int i = 0; i < SCAN_CYC; i++) begin tick(cs); if (abort) return; end
      if (cs == ALL_HIGH) begin m_row = (m_row + 1) % ROWS; continue; end
      // press must be seen unchanged on DEB_CYC consecutive cycles
      m_phase = ST_PRESS_DEB; pat = cs; n = 0; to_scan = 0;
      while (n < DEB_CYC) begin
        tick(cs); if (abort) return;
        if (cs == ALL_HIGH) begin to_scan = 1; break; end
        if (cs != pat) begin pat = cs; n = 0; end else n++;
      end
      if (to_scan) begin m_row = (m_row + 1) % ROWS; continue; end
      single = ($countones(~pat) == 1);
      if (single) begin m_code = m_row * COLS + low_index(pat); emit_vld(0); end
      else m_multi = 1;
      m_phase = ST_HELD; wait_rpt = REPEAT_DLY; released = 0;
      while (!released) begin
        tick(cs); if (abort) return;
        if (cs != ALL_HIGH) begin
          wait_rpt--;
          if (wait_rpt == 0) begin
            wait_rpt = REPEAT_PER;
            if (REPEAT_EN != 0 && single) emit_vld(1);
          end
          continue;
        end
        m_phase = ST_REL_DEB; n = 0;
        while (n < DEB_CYC) begin
          tick(cs); if (abort) return;
          if (cs != ALL_HIGH) break;
          n++;
        end
        if (n == DEB_CYC) begin
          released = 1; m_rel = single; m_row = (m_row + 1) % ROWS;
        end else begin
          m_phase = ST_HELD; wait_rpt = REPEAT_DLY;
        end
      end
    end
  endtask

  initial begin
    s1 = '1; s2 = '1; m_row = 0; m_code = 0; m_phase = ST_SCAN; live = 0;
    forever begin abort = 0; model_run(); end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int c_vld, c_rpt, c_rel, c_multi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cols();
    logic [COLS-1:0] v;
    v = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!key_row[r] && pressed[r][c]) v[c] = 1'b0;
    key_col = v;
  endtask

  task automatic set_key(input int r, input int c, input bit v);
    pressed[r][c] = v;
    drive_cols();
  endtask

  task automatic clear_tally();
    c_vld = 0; c_rpt = 0; c_rel = 0; c_multi = 0;
  endtask

  // one cycle: compare against the model, tally events, refresh columns
  task automatic step();
    logic [ROWS-1:0] er;
    @(negedge clk);
    if (live) begin
      er = '1; er[m_row] = 1'b0;
      chk("key_row", key_row, er);
      chk("key_code", key_code, m_code);
      chk("key_vld", key_vld, m_vld);
      chk("key_rpt", key_rpt, m_rpt);
      chk("key_rel", key_rel, m_rel);
      chk("key_multi", key_multi, m_multi);
      chk("dbg_state", dbg_state, m_phase);
      if (key_vld === 1'b1) begin
        chk("vld_expected", exp_rd < exp_q.size(), 1);
        if (exp_rd < exp_q.size()) begin
          chk("vld_event", {key_rpt, key_code}, exp_q[exp_rd]);
          exp_rd++;
        end
      end
    end
    if (key_vld === 1'b1 && key_rpt === 1'b0) c_vld++;
    if (key_vld === 1'b1 && key_rpt === 1'b1) c_rpt++;
    if (key_rel === 1'b1) c_rel++;
    if (key_multi === 1'b1) c_multi++;
    drive_cols();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // kind: 0 key_vld, 1 key_rel, 2 key_multi
  task automatic wait_pulse(input int kind, input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit && !found; i++) begin
      step();
      case (kind)
        0: found = (key_vld === 1'b1);
        1: found = (key_rel === 1'b1);
        default: found = (key_multi === 1'b1);
      endcase
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit f;
    int r, c, r2, c2;
    clear_tally();
    run(3);
    chk("reset_row", key_row, 4'b1110);
    chk("reset_code", key_code, 0);
    chk("reset_flags", {key_vld, key_rpt, key_rel, key_multi}, 0);
    rst = 1'b0;
    run(5);

    // single key row 2 col 1
    clear_tally();
    set_key(2, 1, 1);
    wait_pulse(0, 200, f);
    chk("k9_vld_seen", f, 1);
    chk("k9_code", key_code, 9);
    chk("k9_rpt", key_rpt, 0);
    run(30);
    set_key(2, 1, 0);
    wait_pulse(1, 100, f);
    chk("k9_rel_seen", f, 1);
    chk("k9_code_after_rel", key_code, 9);
    chk("k9_counts", {c_vld[7:0], c_rpt[7:0], c_rel[7:0]}, 32'h010001);
    run(10);

    // bouncing column 3 on row 0, then steady
    clear_tally();
    for (int t = 0; t < 12; t++) begin
      set_key(0, 3, (t % 2) == 0);
      run(5);
    end
    chk("bounce_no_vld", c_vld, 0);
    set_key(0, 3, 1);
    wait_pulse(0, 200, f);
    chk("k3_vld_seen", f, 1);
    chk("k3_code", key_code, 3);
    chk("k3_single", c_vld, 1);
    set_key(0, 3, 0);
    wait_pulse(1, 100, f);
    chk("k3_rel_seen", f, 1);
    run(10);

    // two keys on row 1
    clear_tally();
    set_key(1, 0, 1); set_key(1, 2, 1);
    wait_pulse(2, 200, f);
    chk("multi_seen", f, 1);
    run(20);
    set_key(1, 0, 0); set_key(1, 2, 0);
    run(60);
    chk("multi_counts", {c_vld[7:0], c_rel[7:0], c_multi[7:0]}, 32'h000001);
    chk("multi_code_kept", key_code, 3);

    // auto-repeat on key 5
    clear_tally();
    set_key(1, 1, 1);
    wait_pulse(0, 200, f);
    chk("k5_vld_seen", f, 1);
    chk("k5_code", key_code, 5);
    chk("k5_first_rpt", key_rpt, 0);
    run(100);
    chk("k5_repeats", c_rpt, 7);
    set_key(1, 1, 0);
    wait_pulse(1, 100, f);
    chk("k5_rel_seen", f, 1);
    chk("k5_rel_count", c_rel, 1);
    run(10);

    // reset while held
    set_key(1, 2, 1);
    wait_pulse(0, 200, f);
    chk("k6_vld_seen", f, 1);
    run(5);
    rst = 1'b1;
    set_key(1, 2, 0);
    step();
    chk("rst_held_row", key_row, 4'b1110);
    chk("rst_held_code", key_code, 0);
    chk("rst_held_flags", {key_vld, key_rpt, key_rel, key_multi}, 0);
    run(2);
    rst = 1'b0;
    clear_tally();
    run(80);
    chk("rst_no_events", {c_vld[7:0], c_rel[7:0]}, 0);

    // short release glitch while held
    set_key(2, 2, 1);
    wait_pulse(0, 200, f);
    chk("k10_vld_seen", f, 1);
    clear_tally();
    run(10);
    set_key(2, 2, 0);
    run(6);
    set_key(2, 2, 1);
    run(20);
    chk("glitch_quiet", {c_vld[7:0], c_rpt[7:0], c_rel[7:0]}, 0);
    set_key(2, 2, 0);
    wait_pulse(1, 100, f);
    chk("k10_rel_seen", f, 1);
    run(10);

    // randomized presses, sometimes with a second key and a glitch
    for (int k = 0; k < 25; k++) begin
      r = $urandom_range(0, ROWS - 1); c = $urandom_range(0, COLS - 1);
      r2 = $urandom_range(0, ROWS - 1); c2 = $urandom_range(0, COLS - 1);
      set_key(r, c, 1);
      if ($urandom_range(0, 3) == 0) set_key(r2, c2, 1);
      run($urandom_range(10, 120));
      if ($urandom_range(0, 2) == 0) begin
        set_key(r, c, 0); run($urandom_range(1, 8)); set_key(r, c, 1);
        run($urandom_range(5, 60));
      end
      set_key(r, c, 0); set_key(r2, c2, 0);
      run($urandom_range(20, 100));
    end
    run(50);
    chk("all_vld_seen", exp_rd, exp_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
